// File: rtl/fd_ratio_ctrl.sv
// Programmable clock divider for the FMDLL feedback/reference path.
// A new half-period is taken over a valid/ready handshake, applied only at a period boundary, then settled is reported.
module fd_ratio_ctrl #(
    parameter int CNT_W    = 8,
    parameter int SETTLE   = 4,
    parameter int RST_HALF = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_half,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             div_out,
    output logic             div_en,
    output logic             busy,
    output logic             settled
);

    localparam int PER_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_PEND,
        ST_SETTLE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] half_q;
    logic [CNT_W-1:0] pend_half;
    logic [CNT_W-1:0] cnt;
    logic [PER_W-1:0] per_cnt;

    logic at_toggle;
    logic pb;

    // The end of a low phase is the only point where a new ratio may be switched in.
    assign at_toggle = (cnt == half_q - CNT_W'(1));
    assign pb        = !div_out && at_toggle;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_SETTLE;
            half_q    <= CNT_W'(RST_HALF);
            pend_half <= CNT_W'(RST_HALF);
            cnt       <= '0;
            div_out   <= 1'b1;
            div_en    <= 1'b0;
            cfg_err   <= 1'b0;
            per_cnt   <= '0;
            settled   <= 1'b0;
            cfg_ready <= 1'b0;
            busy      <= 1'b1;
        end else begin
            div_en  <= pb;
            cfg_err <= 1'b0;

            if (at_toggle) begin
                cnt     <= '0;
                div_out <= ~div_out;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end

            // The switch lands on a normal rising edge, so the core update above already gives cnt=0, div_out=1.
            case (state)
                ST_RUN: begin
                    if (cfg_valid) begin
                        if (cfg_half == '0) begin
                            cfg_err <= 1'b1;
                        end else begin
                            pend_half <= cfg_half;
                            settled   <= 1'b0;
                            cfg_ready <= 1'b0;
                            busy      <= 1'b1;
                            state     <= ST_PEND;
                        end
                    end
                end
                ST_PEND: begin
                    if (pb) begin
                        half_q  <= pend_half;
                        per_cnt <= '0;
                        state   <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (pb) begin
                        if (per_cnt == PER_W'(SETTLE - 1)) begin
                            settled   <= 1'b1;
                            cfg_ready <= 1'b1;
                            busy      <= 1'b0;
                            state     <= ST_RUN;
                        end else begin
                            per_cnt <= per_cnt + PER_W'(1);
                        end
                    end
                end
                default: begin
                    state     <= ST_SETTLE;
                    per_cnt   <= '0;
                    cfg_ready <= 1'b0;
                    busy      <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fd_ratio_ctrl.sv
// Directed-vector bench for fd_ratio_ctrl: a per-cycle expectation table plus a
// hand-written ratio change whose settle time and phase lengths are measured.
module tb_fd_ratio_ctrl;

    logic       clk;
    logic       rst;
    logic       cfg_valid;
    logic [7:0] cfg_half;
    logic       cfg_ready;
    logic       cfg_err;
    logic       div_out;
    logic       div_en;
    logic       busy;
    logic       settled;

    int n_checks = 0;
    int n_fails  = 0;

    typedef struct {
        logic       rst;
        logic       valid;
        logic [7:0] half;
        logic       e_div;
        logic       e_en;
        logic       e_ready;
        logic       e_settled;
        logic       e_err;
    } vec_t;

    vec_t vecs[$];

    fd_ratio_ctrl #(
        .CNT_W   (8),
        .SETTLE  (4),
        .RST_HALF(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_valid(cfg_valid),
        .cfg_half (cfg_half),
        .cfg_ready(cfg_ready),
        .cfg_err  (cfg_err),
        .div_out  (div_out),
        .div_en   (div_en),
        .busy     (busy),
        .settled  (settled)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive the inputs for the next edge, then sample 1 time unit after it.
    task automatic apply_stimulus(input logic r, input logic v, input logic [7:0] h);
        rst       = r;
        cfg_valid = v;
        cfg_half  = h;
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        vec_t v;
        int   d;
        int   n;
        int   hi;
        int   lo;

        // Row c holds the inputs driven into the edge that produces cycle c, and
        // the outputs expected in cycle c. Cycle 0 is the cycle right after reset.
        for (int c = 0; c <= 80; c++) begin
            v = '{default: '0};
            if (c <= 20) begin
                // Default divide-by-4 out of reset, then an illegal zero request at 17.
                v.rst       = (c == 0);
                v.valid     = (c == 17);
                v.e_div     = (c % 4) < 2;
                v.e_en      = (c > 0) && (c % 4 == 0);
                v.e_ready   = (c >= 16);
                v.e_settled = (c >= 16);
                v.e_err     = (c == 17);
            end else if (c <= 48) begin
                // Request 3 accepted into cycle 21; a second value (1) is then held.
                v.valid = 1'b1;
                v.half  = (c == 21) ? 8'd3 : 8'd1;
                if (c < 24) begin
                    v.e_div = (c == 21);
                end else begin
                    d       = c - 24;
                    v.e_div = (d % 6) < 3;
                    v.e_en  = (d % 6) == 0;
                end
                v.e_ready   = (c == 48);
                v.e_settled = (c == 48);
            end else if (c <= 53) begin
                // Held value accepted into cycle 49; old 3/3 period finishes.
                v.valid = (c == 49);
                v.half  = 8'd1;
                d       = c - 24;
                v.e_div = (d % 6) < 3;
            end else if (c <= 62) begin
                // Divide-by-2 from cycle 54.
                d           = c - 54;
                v.e_div     = (d % 2) == 0;
                v.e_en      = (d % 2) == 0;
                v.e_ready   = (c == 62);
                v.e_settled = (c == 62);
            end else if (c == 63) begin
                v.valid = 1'b1;
                v.half  = 8'd5;
                v.e_div = 1'b0;
            end else begin
                // Reset while 5 is pending: back to divide-by-4, 5 never used.
                d           = c - 64;
                v.rst       = (c == 64);
                v.e_div     = (d % 4) < 2;
                v.e_en      = (d > 0) && (d % 4 == 0);
                v.e_ready   = (c == 80);
                v.e_settled = (c == 80);
            end
            vecs.push_back(v);
        end

        rst       = 1'b1;
        cfg_valid = 1'b0;
        cfg_half  = '0;
        repeat (2) @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].rst, vecs[i].valid, vecs[i].half);
            check_output($sformatf("div_out@%0d", i), div_out, vecs[i].e_div);
            check_output($sformatf("div_en@%0d", i), div_en, vecs[i].e_en);
            check_output($sformatf("cfg_ready@%0d", i), cfg_ready, vecs[i].e_ready);
            check_output($sformatf("busy@%0d", i), busy, !vecs[i].e_ready);
            check_output($sformatf("settled@%0d", i), settled, vecs[i].e_settled);
            check_output($sformatf("cfg_err@%0d", i), cfg_err, vecs[i].e_err);
        end

        // Switch from half 2 to half 4: accepted into cycle 81, first new high at 84,
        // fourth new boundary at 115, so settled appears at cycle 116.
        apply_stimulus(1'b0, 1'b1, 8'd4);
        check_output("busy_after_req4", busy, 1'b1);
        cfg_valid = 1'b0;
        n = 81;
        while (!settled && n < 300) begin
            apply_stimulus(1'b0, 1'b0, 8'd0);
            n++;
        end
        check_int("settle_cycle_half4", n, 116);
        check_output("div_en_at_settle_half4", div_en, 1'b1);

        hi = 0;
        while (div_out && hi < 20) begin
            hi++;
            apply_stimulus(1'b0, 1'b0, 8'd0);
        end
        check_int("high_len_half4", hi, 4);
        lo = 0;
        while (!div_out && lo < 20) begin
            lo++;
            apply_stimulus(1'b0, 1'b0, 8'd0);
        end
        check_int("low_len_half4", lo, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
